// File: rtl/bp_fe_pkg.sv
// Front-end shared definitions: hash-mode selectors used by the global-history
// index generator.
package bp_fe_pkg;

  typedef enum logic {
    BP_FE_HASH_GSHARE  = 1'b0,
    BP_FE_HASH_GSELECT = 1'b1
  } bp_fe_hash_mode_e;

  localparam int unsigned bp_fe_hash_gshare_gp  = 0;
  localparam int unsigned bp_fe_hash_gselect_gp = 1;

  // Pointer width for a power-of-two FIFO, excluding the wrap bit.
  function automatic int unsigned bp_fe_ptr_width(input int unsigned els);
    return $clog2(els);
  endfunction

endpackage

// File: rtl/bp_fe_ghist_ckpt_fifo.sv
// In-order checkpoint FIFO with push, pop and clear. Clear wins over push/pop;
// full/empty use wrap-bit pointer comparison.
module bp_fe_ghist_ckpt_fifo
  import bp_fe_pkg::*;
#(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned lg_els_lp = bp_fe_ptr_width(els_p);
  localparam logic [lg_els_lp:0] ptr_one_lp = {{lg_els_lp{1'b0}}, 1'b1};

  logic [lg_els_lp:0] wptr_q, wptr_d;
  logic [lg_els_lp:0] rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [els_p];
  logic               do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[lg_els_lp-1:0] == rptr_q[lg_els_lp-1:0])
                && (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]);
  assign data_o  = mem_q[rptr_q[lg_els_lp-1:0]];

  always_comb begin
    do_push = push_i & ~full_o & ~clear_i;
    do_pop  = pop_i & ~empty_o & ~clear_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clear_i) begin
      // Clearing collapses the read pointer onto the write pointer.
      rptr_d = wptr_q;
    end else begin
      if (do_push) wptr_d = wptr_q + ptr_one_lp;
      if (do_pop)  rptr_d = rptr_q + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[lg_els_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_fe_ghist_idx.sv
// Global-history BHT index generator: hashes fetch PCs with speculative history,
// checkpoints predicted branches, and sequences BHT writes on in-order resolve.
module bp_fe_ghist_idx
  import bp_fe_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 8,
  parameter int unsigned vaddr_width_p   = 39,
  parameter int unsigned ghist_width_p   = 6,
  parameter int unsigned ckpt_els_p      = 8,
  parameter int unsigned hash_mode_p     = bp_fe_hash_gshare_gp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       fetch_v_i,
  input  logic [vaddr_width_p-1:0]   fetch_pc_i,
  output logic                       r_v_o,
  output logic [bht_idx_width_p-1:0] idx_r_o,
  input  logic                       predict_v_i,
  input  logic                       predict_i,
  output logic                       ckpt_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       res_mispredict_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic [ghist_width_p-1:0]   hist;
  } bp_fe_ghist_ckpt_s;

  localparam int unsigned ckpt_width_lp = $bits(bp_fe_ghist_ckpt_s);

  function automatic logic [ghist_width_p-1:0] shift_in(
    input logic [ghist_width_p-1:0] h,
    input logic                     b
  );
    logic [ghist_width_p:0] t;
    t = {h, b};
    return t[ghist_width_p-1:0];
  endfunction

  logic [ghist_width_p-1:0]   spec_hist_q, spec_hist_d;
  logic [ghist_width_p-1:0]   commit_hist_q, commit_hist_d;
  logic                       r_v_q, r_v_d;
  logic [bht_idx_width_p-1:0] idx_r_q, idx_r_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;

  logic                       fifo_full, fifo_empty;
  logic                       res_fire, mispredict, clear, push;
  bp_fe_ghist_ckpt_s          push_data, head;

  logic [bht_idx_width_p-1:0] pc_bits;
  logic [bht_idx_width_p-1:0] hash_idx;
  logic                       unused_pc;

  assign pc_bits   = fetch_pc_i[bht_idx_width_p+1:2];
  assign unused_pc = ^{fetch_pc_i, pc_bits};

  if (hash_mode_p == bp_fe_hash_gshare_gp) begin : g_gshare
    assign hash_idx = pc_bits ^ bht_idx_width_p'(spec_hist_q);
  end else if (ghist_width_p == bht_idx_width_p) begin : g_gselect_hist_only
    assign hash_idx = spec_hist_q;
  end else begin : g_gselect
    assign hash_idx = {pc_bits[bht_idx_width_p-ghist_width_p-1:0], spec_hist_q};
  end

  assign push_data = '{idx: idx_r_q, hist: spec_hist_q};

  bp_fe_ghist_ckpt_fifo #(
    .width_p (ckpt_width_lp),
    .els_p   (ckpt_els_p)
  ) u_ckpt_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (res_fire),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    res_fire   = res_v_i & ~fifo_empty;
    mispredict = res_fire & res_mispredict_i;
    clear      = mispredict | flush_i;
    push       = predict_v_i & ~fifo_full & ~clear;

    commit_hist_d = res_fire ? shift_in(commit_hist_q, res_taken_i) : commit_hist_q;

    // Flush restores the committed view, which already folds in a same-cycle
    // resolve; a mispredict rebuilds from the head checkpoint instead.
    spec_hist_d = spec_hist_q;
    if (flush_i) begin
      spec_hist_d = commit_hist_d;
    end else if (mispredict) begin
      spec_hist_d = shift_in(head.hist, res_taken_i);
    end else if (push) begin
      spec_hist_d = shift_in(spec_hist_q, predict_i);
    end

    r_v_d     = fetch_v_i;
    idx_r_d   = fetch_v_i ? hash_idx : idx_r_q;
    w_v_d     = res_fire;
    idx_w_d   = res_fire ? head.idx : idx_w_q;
    correct_d = res_fire ? ~res_mispredict_i : correct_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
      r_v_q         <= 1'b0;
      idx_r_q       <= '0;
      w_v_q         <= 1'b0;
      idx_w_q       <= '0;
      correct_q     <= 1'b0;
    end else begin
      spec_hist_q   <= spec_hist_d;
      commit_hist_q <= commit_hist_d;
      r_v_q         <= r_v_d;
      idx_r_q       <= idx_r_d;
      w_v_q         <= w_v_d;
      idx_w_q       <= idx_w_d;
      correct_q     <= correct_d;
    end
  end

  assign r_v_o        = r_v_q;
  assign idx_r_o      = idx_r_q;
  assign w_v_o        = w_v_q;
  assign idx_w_o      = idx_w_q;
  assign correct_o    = correct_q;
  assign ckpt_ready_o = ~fifo_full;

endmodule

// File: tb/tb_bp_fe_ghist_idx.sv
// Scoreboard bench for bp_fe_ghist_idx: stimulus queues expected reads/writes,
// a negedge monitor pops and compares whenever the DUT presents r_v_o or w_v_o.
module tb_bp_fe_ghist_idx;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fetch_v_i;
  logic [38:0] fetch_pc_i;
  logic        r_v_o;
  logic [7:0]  idx_r_o;
  logic        predict_v_i, predict_i;
  logic        ckpt_ready_o;
  logic        res_v_i, res_taken_i, res_mispredict_i, flush_i;
  logic        w_v_o;
  logic [7:0]  idx_w_o;
  logic        correct_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_r[$];
  logic [8:0] exp_w[$];
  logic [7:0] inflight[$];
  int unsigned cur;

  always #5 clk_i = ~clk_i;

  bp_fe_ghist_idx #(
    .bht_idx_width_p (8),
    .vaddr_width_p   (39),
    .ghist_width_p   (6),
    .ckpt_els_p      (8),
    .hash_mode_p     (0)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fetch_v_i        (fetch_v_i),
    .fetch_pc_i       (fetch_pc_i),
    .r_v_o            (r_v_o),
    .idx_r_o          (idx_r_o),
    .predict_v_i      (predict_v_i),
    .predict_i        (predict_i),
    .ckpt_ready_o     (ckpt_ready_o),
    .res_v_i          (res_v_i),
    .res_taken_i      (res_taken_i),
    .res_mispredict_i (res_mispredict_i),
    .flush_i          (flush_i),
    .w_v_o            (w_v_o),
    .idx_w_o          (idx_w_o),
    .correct_o        (correct_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    fetch_v_i        = 1'b0;
    predict_v_i      = 1'b0;
    predict_i        = 1'b0;
    res_v_i          = 1'b0;
    res_taken_i      = 1'b0;
    res_mispredict_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [38:0] pc, input logic [7:0] exp_idx);
    fetch_v_i  = 1'b1;
    fetch_pc_i = pc;
    exp_r.push_back(exp_idx);
  endtask

  task automatic resolve(input logic taken, input logic mis, input logic [7:0] exp_idx);
    res_v_i          = 1'b1;
    res_taken_i      = taken;
    res_mispredict_i = mis;
    exp_w.push_back({exp_idx, ~mis});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_v"},     32'(r_v_o),        32'd0);
    check({tag, "_idx_r"},   32'(idx_r_o),      32'd0);
    check({tag, "_w_v"},     32'(w_v_o),        32'd0);
    check({tag, "_idx_w"},   32'(idx_w_o),      32'd0);
    check({tag, "_correct"}, 32'(correct_o),    32'd0);
    check({tag, "_ready"},   32'(ckpt_ready_o), 32'd1);
  endtask

  // Monitor: compare every presented read/write against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i === 1'b1) begin
        if (r_v_o) begin
          if (exp_r.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected: got idx_r_o 0x%0h, expected no read", idx_r_o);
          end else begin
            check("idx_r", 32'(idx_r_o), 32'(exp_r.pop_front()));
          end
        end
        if (w_v_o) begin
          if (exp_w.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_unexpected: got idx_w_o 0x%0h correct %0b, expected no write",
                     idx_w_o, correct_o);
          end else begin
            check("write_idx_correct", 32'({idx_w_o, correct_o}), 32'(exp_w.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] p_idx [5];
    p_idx = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h30};

    idle();
    fetch_pc_i = '0;
    reset_i    = 1'b0;
    #12;
    check_reset_outputs("reset");
    reset_i = 1'b1;

    // Basic read and speculative history build-up.
    fetch(39'h1000, 8'h00);                         tick();
    predict_v_i = 1; predict_i = 1; fetch(39'h1234, 8'h8D); tick();
    predict_v_i = 1; predict_i = 0; fetch(39'h1000, 8'h01); tick();
    predict_v_i = 1; predict_i = 1; fetch(39'h1000, 8'h02); tick();
    fetch(39'h1000, 8'h05);                         tick();

    // Mispredict of the oldest (hist_before = 0), actual not taken.
    resolve(1'b0, 1'b1, 8'h00);                     tick();
    check("ready_after_mispredict", 32'(ckpt_ready_o), 32'd1);
    fetch(39'h1000, 8'h00); res_v_i = 1;            tick();
    tick();

    // Fill the FIFO with idx 1..8, history stays zero.
    fetch(39'h1000 + 39'd4, 8'h01);                 tick();
    cur = 1;
    for (int unsigned i = 1; i <= 8; i++) begin
      predict_v_i = 1; predict_i = 0;
      inflight.push_back(8'(cur));
      fetch(39'h1000 + 39'(4 * (cur + 1)), 8'(cur + 1));
      tick();
      cur++;
    end
    check("ready_full", 32'(ckpt_ready_o), 32'd0);
    predict_v_i = 1; fetch(39'h1000 + 39'(4 * (cur + 1)), 8'(cur + 1)); tick(); cur++;
    check("ready_full_after_drop", 32'(ckpt_ready_o), 32'd0);

    // Resolve with a dropped predict at full, then steady push+pop wrap-around.
    resolve(1'b0, 1'b0, inflight.pop_front());
    predict_v_i = 1; fetch(39'h1000 + 39'(4 * (cur + 1)), 8'(cur + 1)); tick(); cur++;
    check("ready_after_pop", 32'(ckpt_ready_o), 32'd1);
    for (int unsigned j = 0; j < 20; j++) begin
      resolve(j >= 18, 1'b0, inflight.pop_front());
      predict_v_i = 1; predict_i = 0;
      inflight.push_back(8'(cur));
      fetch(39'h1000 + 39'(4 * (cur + 1)), 8'(cur + 1));
      tick();
      cur++;
      check("ready_wrap", 32'(ckpt_ready_o), 32'd1);
    end

    // Flush with coincident correct taken resolve; commit_hist was 0b000011.
    flush_i = 1;
    resolve(1'b1, 1'b0, inflight.pop_front());
    predict_v_i = 1; fetch(39'h1000 + 39'(4 * (cur + 1)), 8'(cur + 1)); tick(); cur++;
    inflight.delete();
    check("ready_after_flush", 32'(ckpt_ready_o), 32'd1);
    fetch(39'h1000, 8'h07); res_v_i = 1;            tick();
    tick();

    // Five checkpoints in flight, then asynchronous reset mid-cycle.
    for (int unsigned p = 0; p < 5; p++) begin
      predict_v_i = 1; predict_i = 0;
      fetch(39'h1000, p_idx[p]);
      tick();
    end
    predict_v_i = 1; resolve(1'b0, 1'b0, 8'h07); fetch(39'h1000, 8'h20); tick();
    @(negedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #1;
    reset_i = 1'b1;

    // First edge after deassertion accepts activity; FIFO starts empty.
    fetch(39'h1000, 8'h00); predict_v_i = 1; predict_i = 1; tick();
    fetch(39'h1000, 8'h01); resolve(1'b1, 1'b0, 8'h00);     tick();
    res_v_i = 1;                                             tick();
    tick();
    tick();

    check("exp_r_drained", 32'(exp_r.size()), 32'd0);
    check("exp_w_drained", 32'(exp_w.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
